// File: rtl/token_pass_sequencer_if.sv
// GLB-side and FIFO-requester bundle for token_pass_sequencer.
// The master modport is the sequencer's view; slave is the requester/GLB environment.
interface token_pass_sequencer_if #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 32,
  parameter int WEB_W  = 4
);
  logic [NUM_CH-1:0]        ifmap_req_i;
  logic [NUM_CH*ADDR_W-1:0] ifmap_addr_i;
  logic [NUM_CH-1:0]        ipsum_req_i;
  logic [NUM_CH*ADDR_W-1:0] ipsum_addr_i;
  logic [NUM_CH-1:0]        opsum_req_i;
  logic [NUM_CH*ADDR_W-1:0] opsum_addr_i;
  logic [NUM_CH*WEB_W-1:0]  opsum_web_i;
  logic [NUM_CH-1:0]        opsum_fifo_empty_i;
  logic [NUM_CH-1:0]        ifmap_gnt_o;
  logic [NUM_CH-1:0]        ipsum_gnt_o;
  logic [NUM_CH-1:0]        opsum_gnt_o;
  logic                     glb_ready_i;
  logic                     glb_req_o;
  logic                     glb_we_o;
  logic [ADDR_W-1:0]        glb_addr_o;
  logic [WEB_W-1:0]         glb_web_o;

  modport master (
    input  ifmap_req_i, ifmap_addr_i, ipsum_req_i, ipsum_addr_i,
           opsum_req_i, opsum_addr_i, opsum_web_i, opsum_fifo_empty_i, glb_ready_i,
    output ifmap_gnt_o, ipsum_gnt_o, opsum_gnt_o,
           glb_req_o, glb_we_o, glb_addr_o, glb_web_o
  );

  modport slave (
    output ifmap_req_i, ifmap_addr_i, ipsum_req_i, ipsum_addr_i,
           opsum_req_i, opsum_addr_i, opsum_web_i, opsum_fifo_empty_i, glb_ready_i,
    input  ifmap_gnt_o, ipsum_gnt_o, opsum_gnt_o,
           glb_req_o, glb_we_o, glb_addr_o, glb_web_o
  );
endinterface

// File: rtl/token_pass_sequencer.sv
// Pass FSM (IDLE..DONE) plus single-port GLB arbiter for ifmap/ipsum/opsum requesters.
// Optional macro TOKEN_RR_EN: round-robin within each class (default: lowest index wins).
module token_pass_sequencer #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 32,
  parameter int WEB_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pass_start_i,
  input  logic       pass_abort_i,
  output logic       pass_done_o,
  input  logic       weight_load_done_i,
  input  logic       init_done_i,
  input  logic       preheat_done_i,
  input  logic       normal_done_i,
  output logic [2:0] state_o,
  token_pass_sequencer_if.master bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WLOAD   = 3'd1,
    S_INIT    = 3'd2,
    S_PREHEAT = 3'd3,
    S_NORMAL  = 3'd4,
    S_DRAIN   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   abort_act, drain_ok, rd_en, wr_en;

  // First requesting index at or after ptr (wrapping); MSB of the result flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [NUM_CH-1:0] req,
                                          input logic [IDX_W-1:0]  ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (int'(i) >= NUM_CH - 1) ? '0 : i + 1'b1;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    abort_act = pass_abort_i && (state_q != S_IDLE);
    drain_ok  = (&bus.opsum_fifo_empty_i) && !(|bus.opsum_req_i);
    state_d   = state_q;
    if (abort_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (pass_start_i && !pass_abort_i) state_d = S_WLOAD;
        S_WLOAD:   if (weight_load_done_i)            state_d = S_INIT;
        S_INIT:    if (init_done_i)                   state_d = S_PREHEAT;
        S_PREHEAT: if (preheat_done_i)                state_d = S_NORMAL;
        S_NORMAL:  if (normal_done_i)                 state_d = S_DRAIN;
        S_DRAIN:   if (drain_ok)                      state_d = S_DONE;
        S_DONE:                                       state_d = S_IDLE;
        default:                                      state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o     = state_q;
    pass_done_o = (state_q == S_DONE) && !pass_abort_i;
    rd_en       = (state_q == S_PREHEAT) || (state_q == S_NORMAL);
    wr_en       = (state_q == S_NORMAL)  || (state_q == S_DRAIN);
  end

  // ---------------- class pointers ----------------
  logic [IDX_W-1:0] ifmap_ptr, ipsum_ptr, opsum_ptr;
  logic             ifmap_sel, ipsum_sel, opsum_sel;
  logic [IDX_W:0]   ifmap_pick, ipsum_pick, opsum_pick;

`ifdef TOKEN_RR_EN
  logic [IDX_W-1:0] ifmap_ptr_q, ifmap_ptr_d, ipsum_ptr_q, ipsum_ptr_d, opsum_ptr_q, opsum_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_ptr_q <= '0;
      ipsum_ptr_q <= '0;
      opsum_ptr_q <= '0;
    end else begin
      ifmap_ptr_q <= ifmap_ptr_d;
      ipsum_ptr_q <= ipsum_ptr_d;
      opsum_ptr_q <= opsum_ptr_d;
    end
  end

  always_comb begin
    ifmap_ptr_d = ifmap_ptr_q;
    ipsum_ptr_d = ipsum_ptr_q;
    opsum_ptr_d = opsum_ptr_q;
    if (state_d == S_IDLE) begin
      ifmap_ptr_d = '0;
      ipsum_ptr_d = '0;
      opsum_ptr_d = '0;
    end else begin
      if (ifmap_sel) ifmap_ptr_d = nxt(ifmap_pick[IDX_W-1:0]);
      if (ipsum_sel) ipsum_ptr_d = nxt(ipsum_pick[IDX_W-1:0]);
      if (opsum_sel) opsum_ptr_d = nxt(opsum_pick[IDX_W-1:0]);
    end
  end

  assign ifmap_ptr = ifmap_ptr_q;
  assign ipsum_ptr = ipsum_ptr_q;
  assign opsum_ptr = opsum_ptr_q;
`else
  assign ifmap_ptr = '0;
  assign ipsum_ptr = '0;
  assign opsum_ptr = '0;
`endif

  // ---------------- arbitration (opsum > ipsum > ifmap) ----------------
  logic [NUM_CH-1:0] ifmap_gnt, ipsum_gnt, opsum_gnt;
  logic              go;
  logic              glb_req_q, glb_req_d, glb_we_q, glb_we_d;
  logic [ADDR_W-1:0] glb_addr_q, glb_addr_d;
  logic [WEB_W-1:0]  glb_web_q, glb_web_d;

  always_comb begin
    ifmap_pick = pick(bus.ifmap_req_i, ifmap_ptr);
    ipsum_pick = pick(bus.ipsum_req_i, ipsum_ptr);
    opsum_pick = pick(bus.opsum_req_i, opsum_ptr);
    go         = bus.glb_ready_i && !abort_act;
    opsum_sel  = go && wr_en && opsum_pick[IDX_W];
    ipsum_sel  = go && rd_en && ipsum_pick[IDX_W] && !opsum_sel;
    ifmap_sel  = go && rd_en && ifmap_pick[IDX_W] && !opsum_sel && !ipsum_sel;
    ifmap_gnt  = '0;
    ipsum_gnt  = '0;
    opsum_gnt  = '0;
    glb_req_d  = opsum_sel || ipsum_sel || ifmap_sel;
    glb_we_d   = glb_we_q;
    glb_addr_d = glb_addr_q;
    glb_web_d  = glb_web_q;
    if (opsum_sel) begin
      opsum_gnt[opsum_pick[IDX_W-1:0]] = 1'b1;
      glb_we_d   = 1'b1;
      glb_addr_d = bus.opsum_addr_i[int'(opsum_pick[IDX_W-1:0])*ADDR_W +: ADDR_W];
      glb_web_d  = bus.opsum_web_i[int'(opsum_pick[IDX_W-1:0])*WEB_W +: WEB_W];
    end else if (ipsum_sel) begin
      ipsum_gnt[ipsum_pick[IDX_W-1:0]] = 1'b1;
      glb_we_d   = 1'b0;
      glb_addr_d = bus.ipsum_addr_i[int'(ipsum_pick[IDX_W-1:0])*ADDR_W +: ADDR_W];
      glb_web_d  = '0;
    end else if (ifmap_sel) begin
      ifmap_gnt[ifmap_pick[IDX_W-1:0]] = 1'b1;
      glb_we_d   = 1'b0;
      glb_addr_d = bus.ifmap_addr_i[int'(ifmap_pick[IDX_W-1:0])*ADDR_W +: ADDR_W];
      glb_web_d  = '0;
    end
  end

  // ---------------- registered GLB command ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      glb_req_q  <= 1'b0;
      glb_we_q   <= 1'b0;
      glb_addr_q <= '0;
      glb_web_q  <= '0;
    end else begin
      glb_req_q  <= glb_req_d;
      glb_we_q   <= glb_we_d;
      glb_addr_q <= glb_addr_d;
      glb_web_q  <= glb_web_d;
    end
  end

  assign bus.ifmap_gnt_o = ifmap_gnt;
  assign bus.ipsum_gnt_o = ipsum_gnt;
  assign bus.opsum_gnt_o = opsum_gnt;
  assign bus.glb_req_o   = glb_req_q;
  assign bus.glb_we_o    = glb_we_q;
  assign bus.glb_addr_o  = glb_addr_q;
  assign bus.glb_web_o   = glb_web_q;
endmodule

// File: tb/tb_token_pass_sequencer.sv
// Directed bench for token_pass_sequencer: FSM walk, arbitration, back-pressure, drain, abort, reset.
module tb_token_pass_sequencer;
  localparam int NUM_CH = 32;
  localparam int ADDR_W = 32;
  localparam int WEB_W  = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WEB_W-1:0]  web;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pass_start = 1'b0, pass_abort = 1'b0;
  logic       wld = 1'b0, initd = 1'b0, pred = 1'b0, nrmd = 1'b0;
  logic       pass_done;
  logic [2:0] state;
  int         tests = 0;
  int         fails = 0;
  txn_t       sbq[$];

  token_pass_sequencer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WEB_W(WEB_W)) bus ();

  token_pass_sequencer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WEB_W(WEB_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .pass_start_i       (pass_start),
    .pass_abort_i       (pass_abort),
    .pass_done_o        (pass_done),
    .weight_load_done_i (wld),
    .init_done_i        (initd),
    .preheat_done_i     (pred),
    .normal_done_i      (nrmd),
    .state_o            (state),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] a_if(input int i); return 32'h1000_0000 + 32'(i * 4);  endfunction
  function automatic logic [ADDR_W-1:0] a_ip(input int i); return 32'h2000_0000 + 32'(i);      endfunction
  function automatic logic [ADDR_W-1:0] a_op(input int i); return 32'h3000_0000 + 32'(i * 16); endfunction
  function automatic logic [WEB_W-1:0]  w_op(input int i); return 4'((i % 15) + 1);            endfunction

  function automatic int oh2i(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Registered GLB command must match the oldest expected grant, or be idle.
  task automatic sb_check();
    txn_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("glb_req",  64'(bus.glb_req_o),  64'd1);
      chk("glb_we",   64'(bus.glb_we_o),   64'(e.we));
      chk("glb_addr", 64'(bus.glb_addr_o), 64'(e.addr));
      chk("glb_web",  64'(bus.glb_web_o),  64'(e.web));
    end else begin
      chk("glb_req_idle", 64'(bus.glb_req_o), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic chk_gnt(input string tag, input logic [31:0] e_if, input logic [31:0] e_ip,
                         input logic [31:0] e_op);
    txn_t t;
    #1;
    chk({tag, "/ifmap_gnt"}, 64'(bus.ifmap_gnt_o), 64'(e_if));
    chk({tag, "/ipsum_gnt"}, 64'(bus.ipsum_gnt_o), 64'(e_ip));
    chk({tag, "/opsum_gnt"}, 64'(bus.opsum_gnt_o), 64'(e_op));
    if (e_op != 0) begin
      t.we = 1'b1; t.addr = a_op(oh2i(e_op)); t.web = w_op(oh2i(e_op)); sbq.push_back(t);
    end else if (e_ip != 0) begin
      t.we = 1'b0; t.addr = a_ip(oh2i(e_ip)); t.web = '0; sbq.push_back(t);
    end else if (e_if != 0) begin
      t.we = 1'b0; t.addr = a_if(oh2i(e_if)); t.web = '0; sbq.push_back(t);
    end
  endtask

  task automatic run_to(input logic [2:0] tgt);
    pass_start = 1'b1; tick(); pass_start = 1'b0; chk("run/wload", 64'(state), 64'd1);
    if (tgt >= 3'd2) begin wld   = 1'b1; tick(); wld   = 1'b0; chk("run/init",    64'(state), 64'd2); end
    if (tgt >= 3'd3) begin initd = 1'b1; tick(); initd = 1'b0; chk("run/preheat", 64'(state), 64'd3); end
    if (tgt >= 3'd4) begin pred  = 1'b1; tick(); pred  = 1'b0; chk("run/normal",  64'(state), 64'd4); end
    if (tgt >= 3'd5) begin nrmd  = 1'b1; tick(); nrmd  = 1'b0; chk("run/drain",   64'(state), 64'd5); end
  endtask

  initial begin
    bus.ifmap_req_i = '0;
    bus.ipsum_req_i = '0;
    bus.opsum_req_i = '0;
    bus.opsum_fifo_empty_i = '1;
    bus.glb_ready_i = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ifmap_addr_i[i*ADDR_W +: ADDR_W] = a_if(i);
      bus.ipsum_addr_i[i*ADDR_W +: ADDR_W] = a_ip(i);
      bus.opsum_addr_i[i*ADDR_W +: ADDR_W] = a_op(i);
      bus.opsum_web_i[i*WEB_W +: WEB_W]    = w_op(i);
    end

    // reset values
    rst = 1'b1; tick(); tick();
    chk("rst/state",     64'(state),           64'd0);
    chk("rst/pass_done", 64'(pass_done),       64'd0);
    chk("rst/ifmap_gnt", 64'(bus.ifmap_gnt_o), 64'd0);
    chk("rst/glb_we",    64'(bus.glb_we_o),    64'd0);
    chk("rst/glb_addr",  64'(bus.glb_addr_o),  64'd0);
    chk("rst/glb_web",   64'(bus.glb_web_o),   64'd0);
    rst = 1'b0;

    // start together with abort is ignored
    pass_start = 1'b1; pass_abort = 1'b1; tick(); pass_start = 1'b0; pass_abort = 1'b0;
    chk("start_abort/state", 64'(state), 64'd0);

    // full pass with empty opsum FIFOs
    run_to(3'd5);
    chk("pass1/done_early", 64'(pass_done), 64'd0);
    tick();
    chk("pass1/state_done", 64'(state), 64'd6);
    chk("pass1/pass_done",  64'(pass_done), 64'd1);
    tick();
    chk("pass1/state_idle", 64'(state), 64'd0);
    chk("pass1/done_clear", 64'(pass_done), 64'd0);

    // PREHEAT: opsum class disabled
    run_to(3'd3);
    bus.opsum_req_i = 32'h1;
    chk_gnt("pre_op_off", 32'h0, 32'h0, 32'h0);
    tick(); bus.opsum_req_i = '0;

    // ifmap_req 0xF held five cycles
    bus.ifmap_req_i = 32'hF;
    for (int k = 0; k < 5; k++) begin
`ifdef TOKEN_RR_EN
      chk_gnt("rr", 32'(1 << (k % 4)), 32'h0, 32'h0);
`else
      chk_gnt("fixed", 32'h1, 32'h0, 32'h0);
`endif
      tick();
    end
    bus.ifmap_req_i = '0;

    // back-pressure then release
    bus.ifmap_req_i = 32'h1; bus.glb_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_gnt("not_ready", 32'h0, 32'h0, 32'h0);
      tick();
    end
    bus.glb_ready_i = 1'b1;
    chk_gnt("ready", 32'h1, 32'h0, 32'h0);
    tick(); bus.ifmap_req_i = '0;

    // NORMAL: class priority
    pred = 1'b1; tick(); pred = 1'b0;
    chk("pass2/normal", 64'(state), 64'd4);
    bus.ifmap_req_i = 32'h5; bus.ipsum_req_i = 32'h2; bus.opsum_req_i = 32'h8;
    chk_gnt("prio_op", 32'h0, 32'h0, 32'h8);
    tick(); bus.ifmap_req_i = '0; bus.ipsum_req_i = '0; bus.opsum_req_i = '0;
    bus.ifmap_req_i = 32'h1; bus.ipsum_req_i = 32'h2;
    chk_gnt("prio_ip", 32'h0, 32'h2, 32'h0);
    tick(); bus.ifmap_req_i = '0; bus.ipsum_req_i = '0;
    bus.ifmap_req_i = 32'h1;
    chk_gnt("ifmap_only", 32'h1, 32'h0, 32'h0);
    tick(); bus.ifmap_req_i = '0;

    // abort in NORMAL squashes the grant
    bus.opsum_req_i = 32'h1; pass_abort = 1'b1;
    chk_gnt("abort", 32'h0, 32'h0, 32'h0);
    chk("abort/pass_done", 64'(pass_done), 64'd0);
    tick(); pass_abort = 1'b0; bus.opsum_req_i = '0;
    chk("abort/state", 64'(state), 64'd0);
    chk("abort/no_done", 64'(pass_done), 64'd0);
    tick();
    chk("abort/no_done2", 64'(pass_done), 64'd0);

    // DRAIN waits on opsum FIFO 0
    bus.opsum_fifo_empty_i = 32'hFFFF_FFFE;
    run_to(3'd5);
    tick();
    chk("drain/hold", 64'(state), 64'd5);
    bus.ifmap_req_i = 32'h1; bus.opsum_req_i = 32'h4;
    chk_gnt("drain_op", 32'h0, 32'h0, 32'h4);
    tick(); bus.opsum_req_i = '0;
    chk("drain/hold2", 64'(state), 64'd5);
    chk_gnt("drain_rd_off", 32'h0, 32'h0, 32'h0);
    tick(); bus.ifmap_req_i = '0;
    bus.opsum_fifo_empty_i = '1;
    tick();
    chk("drain/done", 64'(state), 64'd6);
    chk("drain/pass_done", 64'(pass_done), 64'd1);
    tick();
    chk("drain/idle", 64'(state), 64'd0);

    // reset mid-pass
    run_to(3'd4);
    bus.opsum_req_i = 32'h1;
    chk_gnt("pre_rst", 32'h0, 32'h0, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst/state",     64'(state),           64'd0);
    chk("mid_rst/opsum_gnt", 64'(bus.opsum_gnt_o), 64'd0);
    chk("mid_rst/glb_we",    64'(bus.glb_we_o),    64'd0);
    chk("mid_rst/glb_addr",  64'(bus.glb_addr_o),  64'd0);
    chk("mid_rst/glb_web",   64'(bus.glb_web_o),   64'd0);
    chk("mid_rst/pass_done", 64'(pass_done),       64'd0);
    rst = 1'b0; bus.opsum_req_i = '0;
    tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
